// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding,
// the bubble instruction and the default fetch address after reset.
package if_stage_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Sequential fetch step; wraps modulo 2^32.
   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched instruction, holds, or
// flushes to a bubble (NOP, invalid) while keeping the last PC.
module if_id_reg
   import if_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        flush,
   input  logic [31:0] pc_in,
   input  logic [31:0] instr_in,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_valid
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_pc    <= '0;
         if_instr <= NOP_INSTR;
         if_valid <= 1'b0;
      end else if (flush) begin
         if_instr <= NOP_INSTR;
         if_valid <= 1'b0;
      end else if (load) begin
         if_pc    <= pc_in;
         if_instr <= instr_in;
         if_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: request FSM, PC, pending branch target and a
// one-entry buffer for a word that arrives while decode is frozen.
module if_stage
   import if_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        if_valid
);

   state_t      state;
   logic [31:0] pc;
   logic [31:0] target;
   logic [31:0] hold_buf;
   logic [31:0] pc_plus4;
   logic [31:0] branch_tgt;
   logic        resp;
   logic        id_load;
   logic        id_flush;
   logic [31:0] id_instr;
   logic        unused_addr_bits;

   assign pc_plus4         = pc_inc(pc);
   assign branch_tgt       = {branch_addr[31:2], 2'b00};
   assign unused_addr_bits = ^branch_addr[1:0];
   assign resp             = imem_req & imem_ready;
   assign imem_addr        = {pc[31:2], 2'b00};

   // IF/ID control: branch flushes first, then freeze holds, else load or bubble.
   always_comb begin
      id_load  = 1'b0;
      id_flush = 1'b0;
      id_instr = imem_rdata;
      unique case (state)
         IDLE: begin
         end
         REQ: begin
            if (branch_taken)
               id_flush = 1'b1;
            else if (!freeze) begin
               if (resp)
                  id_load = 1'b1;
               else
                  id_flush = 1'b1;
            end
         end
         HOLD: begin
            id_instr = hold_buf;
            if (branch_taken)
               id_flush = 1'b1;
            else if (!freeze)
               id_load = 1'b1;
         end
         DRAIN: begin
            if (branch_taken || !freeze)
               id_flush = 1'b1;
         end
      endcase
   end

   // PC only moves on leaving DRAIN, so the outstanding address stays stable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         pc       <= {RESET_PC[31:2], 2'b00};
         target   <= '0;
         hold_buf <= '0;
         imem_req <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               state    <= REQ;
               imem_req <= 1'b1;
            end
            REQ: begin
               if (branch_taken) begin
                  if (resp)
                     pc <= branch_tgt;
                  else begin
                     target <= branch_tgt;
                     state  <= DRAIN;
                  end
               end else if (resp) begin
                  if (freeze) begin
                     hold_buf <= imem_rdata;
                     state    <= HOLD;
                     imem_req <= 1'b0;
                  end else
                     pc <= pc_plus4;
               end
            end
            HOLD: begin
               if (branch_taken) begin
                  pc       <= branch_tgt;
                  state    <= REQ;
                  imem_req <= 1'b1;
               end else if (!freeze) begin
                  pc       <= pc_plus4;
                  state    <= REQ;
                  imem_req <= 1'b1;
               end
            end
            DRAIN: begin
               if (branch_taken) begin
                  target <= branch_tgt;
                  if (resp) begin
                     pc    <= branch_tgt;
                     state <= REQ;
                  end
               end else if (resp) begin
                  pc    <= target;
                  state <= REQ;
               end
            end
         endcase
      end
   end

   if_id_reg u_if_id_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (id_load),
      .flush    (id_flush),
      .pc_in    (pc_plus4),
      .instr_in (id_instr),
      .if_pc    (if_pc),
      .if_instr (if_instr),
      .if_valid (if_valid)
   );

endmodule
